// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package fetch_pkg;

    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue: DEPTH entries of W bits, flush clears pointers and count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, queues fetched words for decode,
// handles redirects and halts on EBREAK. FETCH_PERF_CNT_EN adds perf counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 6,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [PC_W-1:0]    out_pc,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = 32 + PC_W;

    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [CW-1:0]   count;
    logic [W-1:0]    head;
    logic            push;
    logic            pop;
    logic            unused_rpc_lsb;

    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign imem_addr = pc[IMEM_AW+1:2];
    assign halted    = (state == ST_HALT);
    // Handshakes are blocked during a redirect so the flushed head is never consumed.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (state == ST_RUN) && !redirect_valid && ((count < CW'(DEPTH)) || pop);
    assign out_inst  = head[W-1:PC_W];
    assign out_pc    = head[PC_W-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({imem_data, pc}),
        .dout  (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            state_nxt = ST_RUN;
            pc_nxt    = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (push) begin
            pc_nxt = pc + PC_W'(4);
            if (imem_data == EBREAK_INST)
                state_nxt = ST_HALT;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 32'd1;
            // In RUN without redirect, a missing push can only mean a full queue.
            if (state == ST_RUN && !redirect_valid && !push)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
